// File: rtl/drop_sequencer.sv
// drop_sequencer: once-per-frame game-flow controller for the falling-block playfield.
// It decides what the active piece does each frame and drives the piece mover and
// the playfield grid with one-cycle command strobes. After each lock it scans the
// rows for full lines and clears them, then updates the line count and level.
// Optional feature: define DROP_SEQ_AUTOREPEAT_EN to repeat lateral moves while a/d is held.
module drop_sequencer #(
    parameter int GRAV_INIT       = 48,
    parameter int GRAV_DEC        = 4,
    parameter int GRAV_MIN        = 4,
    parameter int LOCK_DELAY      = 30,
    parameter int LINES_PER_LEVEL = 10,
    parameter int ROWS            = 30
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode_i,
    input  logic       blocked_down_i,
    input  logic       blocked_left_i,
    input  logic       blocked_right_i,
    input  logic       blocked_rot_i,
    input  logic       spawn_blocked_i,
    input  logic       row_full_i,
    output logic       spawn_o,
    output logic [1:0] step_x_o,
    output logic       step_y_o,
    output logic       rotate_o,
    output logic       lock_o,
    output logic       clear_row_o,
    output logic [4:0] scan_row_o,
    output logic [7:0] lines_o,
    output logic [3:0] level_o,
    output logic       game_over_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        SPAWN    = 3'd0,
        FALL     = 3'd1,
        LOCKWAIT = 3'd2,
        HARD     = 3'd3,
        LOCK     = 3'd4,
        SCAN     = 3'd5,
        CLEAR    = 3'd6,
        OVER     = 3'd7
    } state_t;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_ROT   = 8'h1A;
    localparam logic [7:0] KEY_SOFT  = 8'h16;
    localparam logic [7:0] KEY_HARD  = 8'h2C;

    state_t     state_q;
    logic [7:0] prevKey_q;
    logic [7:0] gravCnt_q;
    logic [7:0] lockCnt_q;
    logic [4:0] scanRow_q;
    logic [7:0] lines_q;
    logic [3:0] level_q;
    logic [3:0] lvlCnt_q;
    logic       gameOver_q;
    logic       spawn_q;
    logic [1:0] stepX_q;
    logic       stepY_q;
    logic       rotate_q;
    logic       lock_q;
    logic       clearRow_q;

    logic       keyNew;
    logic       busy;
    logic       repeatTick;
    logic [7:0] levelDec;
    logic [7:0] basePeriod;
    logic [7:0] period;
    logic [7:0] periodM1;
    logic       gravDue;
    logic [7:0] gravCnt_d;
    logic [7:0] lockCnt_d;
    logic [7:0] lines_d;
    logic [3:0] level_d;
    logic [3:0] lvlCnt_d;
    logic       hardReq;
    logic       leftReq;
    logic       rightReq;
    logic       rotReq;

    // A command key counts only on the cycle it first appears; the cycle right
    // after any strobe belongs to the mover/grid, so inputs are not trusted then.
    assign keyNew = (keycode_i != prevKey_q);
    assign busy   = spawn_q | (|stepX_q) | stepY_q | rotate_q | lock_q | clearRow_q;

`ifdef DROP_SEQ_AUTOREPEAT_EN
    logic [4:0] repCnt_q;

    // Frames since the last key change; folds 19 back to 16 so a held key repeats every 4 frames
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            repCnt_q <= '0;
        end else if (keyNew) begin
            repCnt_q <= 5'd1;
        end else if (repCnt_q == 5'd19) begin
            repCnt_q <= 5'd16;
        end else begin
            repCnt_q <= repCnt_q + 5'd1;
        end
    end

    assign repeatTick = !keyNew && (repCnt_q == 5'd16);
`else
    assign repeatTick = 1'b0;
`endif

    // Gravity period, saturating counter next-values and decoded move requests
    always_comb begin
        levelDec = 8'(int'(level_q) * GRAV_DEC);
        if (int'(levelDec) + GRAV_MIN >= GRAV_INIT) begin
            basePeriod = 8'(GRAV_MIN);
        end else begin
            basePeriod = 8'(GRAV_INIT) - levelDec;
        end
        period    = (keycode_i == KEY_SOFT) ? 8'd1 : basePeriod;
        periodM1  = period - 8'd1;
        gravDue   = (gravCnt_q >= periodM1);
        gravCnt_d = gravDue ? periodM1 : gravCnt_q + 8'd1;
        lockCnt_d = (lockCnt_q == 8'hFF) ? lockCnt_q : lockCnt_q + 8'd1;
        lines_d   = (lines_q == 8'hFF) ? lines_q : lines_q + 8'd1;
        if (lvlCnt_q == 4'(LINES_PER_LEVEL - 1)) begin
            lvlCnt_d = 4'd0;
            level_d  = (level_q == 4'hF) ? level_q : level_q + 4'd1;
        end else begin
            lvlCnt_d = lvlCnt_q + 4'd1;
            level_d  = level_q;
        end
        hardReq  = keyNew && (keycode_i == KEY_HARD);
        leftReq  = (keyNew || repeatTick) && (keycode_i == KEY_LEFT) && !blocked_left_i;
        rightReq = (keyNew || repeatTick) && (keycode_i == KEY_RIGHT) && !blocked_right_i;
        rotReq   = keyNew && (keycode_i == KEY_ROT) && !blocked_rot_i;
    end

    // Game-flow FSM: one decision per frame, every output registered
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q    <= SPAWN;
            prevKey_q  <= 8'h00;
            gravCnt_q  <= '0;
            lockCnt_q  <= '0;
            scanRow_q  <= '0;
            lines_q    <= '0;
            level_q    <= '0;
            lvlCnt_q   <= '0;
            gameOver_q <= 1'b0;
            spawn_q    <= 1'b0;
            stepX_q    <= 2'b00;
            stepY_q    <= 1'b0;
            rotate_q   <= 1'b0;
            lock_q     <= 1'b0;
            clearRow_q <= 1'b0;
        end else begin
            prevKey_q  <= keycode_i;
            spawn_q    <= 1'b0;
            stepX_q    <= 2'b00;
            stepY_q    <= 1'b0;
            rotate_q   <= 1'b0;
            lock_q     <= 1'b0;
            clearRow_q <= 1'b0;
            case (state_q)
                SPAWN: begin
                    if (!busy) begin
                        if (spawn_blocked_i) begin
                            state_q    <= OVER;
                            gameOver_q <= 1'b1;
                        end else begin
                            spawn_q   <= 1'b1;
                            gravCnt_q <= '0;
                            lockCnt_q <= '0;
                            state_q   <= FALL;
                        end
                    end
                end
                FALL: begin
                    gravCnt_q <= gravCnt_d;
                    if (!busy) begin
                        if (hardReq) begin
                            state_q <= HARD;
                        end else if (rightReq) begin
                            stepX_q <= 2'b01;
                        end else if (leftReq) begin
                            stepX_q <= 2'b11;
                        end else if (rotReq) begin
                            rotate_q <= 1'b1;
                        end else if (gravDue) begin
                            if (blocked_down_i) begin
                                state_q <= LOCKWAIT;
                            end else begin
                                stepY_q   <= 1'b1;
                                gravCnt_q <= '0;
                            end
                        end
                    end
                end
                LOCKWAIT: begin
                    lockCnt_q <= lockCnt_d;
                    if (!busy && hardReq) begin
                        state_q <= LOCK;
                    end else if (!busy && !blocked_down_i) begin
                        state_q   <= FALL;
                        gravCnt_q <= '0;
                    end else if (lockCnt_q == 8'(LOCK_DELAY - 1)) begin
                        state_q <= LOCK;
                    end else if (!busy) begin
                        if (rightReq) begin
                            stepX_q <= 2'b01;
                        end else if (leftReq) begin
                            stepX_q <= 2'b11;
                        end else if (rotReq) begin
                            rotate_q <= 1'b1;
                        end
                    end
                end
                HARD: begin
                    if (!busy) begin
                        if (blocked_down_i) begin
                            state_q <= LOCK;
                        end else begin
                            stepY_q <= 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (!busy) begin
                        lock_q    <= 1'b1;
                        scanRow_q <= 5'(ROWS - 1);
                        state_q   <= SCAN;
                    end
                end
                SCAN: begin
                    if (!busy) begin
                        if (row_full_i) begin
                            clearRow_q <= 1'b1;
                            state_q    <= CLEAR;
                        end else if (scanRow_q == 5'd0) begin
                            state_q <= SPAWN;
                        end else begin
                            scanRow_q <= scanRow_q - 5'd1;
                        end
                    end
                end
                CLEAR: begin
                    lines_q  <= lines_d;
                    level_q  <= level_d;
                    lvlCnt_q <= lvlCnt_d;
                    state_q  <= SCAN;
                end
                OVER: begin
                    gameOver_q <= 1'b1;
                end
                default: begin
                    state_q <= SPAWN;
                end
            endcase
        end
    end

    assign spawn_o     = spawn_q;
    assign step_x_o    = stepX_q;
    assign step_y_o    = stepY_q;
    assign rotate_o    = rotate_q;
    assign lock_o      = lock_q;
    assign clear_row_o = clearRow_q;
    assign scan_row_o  = scanRow_q;
    assign lines_o     = lines_q;
    assign level_o     = level_q;
    assign game_over_o = gameOver_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_drop_sequencer.sv
// tb_drop_sequencer: directed, self-checking bench for drop_sequencer.
// A small row-occupancy model stands in for the playfield grid so row_full and
// clear_row interact the way the real grid would; blocked_* are driven directly.
module tb_drop_sequencer;

    localparam int ST_SPAWN    = 0;
    localparam int ST_FALL     = 1;
    localparam int ST_LOCKWAIT = 2;
    localparam int ST_HARD     = 3;
    localparam int ST_LOCK     = 4;
    localparam int ST_SCAN     = 5;
    localparam int ST_OVER     = 7;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_ROT   = 8'h1A;
    localparam logic [7:0] KEY_SOFT  = 8'h16;
    localparam logic [7:0] KEY_HARD  = 8'h2C;

    logic        frameClk = 1'b0;
    logic        reset;
    logic [7:0]  keycode;
    logic        blockedDown, blockedLeft, blockedRight, blockedRot, spawnBlocked;
    logic        rowFull;
    logic        spawn, stepY, rotate, lock, clearRow, gameOver;
    logic [1:0]  stepX;
    logic [4:0]  scanRow;
    logic [7:0]  lines;
    logic [3:0]  level;
    logic [2:0]  state;
    logic [29:0] fullRows;

    int errorCount = 0;
    int checkCount = 0;

    drop_sequencer dut (
        .frame_clk       (frameClk),
        .Reset           (reset),
        .keycode_i       (keycode),
        .blocked_down_i  (blockedDown),
        .blocked_left_i  (blockedLeft),
        .blocked_right_i (blockedRight),
        .blocked_rot_i   (blockedRot),
        .spawn_blocked_i (spawnBlocked),
        .row_full_i      (rowFull),
        .spawn_o         (spawn),
        .step_x_o        (stepX),
        .step_y_o        (stepY),
        .rotate_o        (rotate),
        .lock_o          (lock),
        .clear_row_o     (clearRow),
        .scan_row_o      (scanRow),
        .lines_o         (lines),
        .level_o         (level),
        .game_over_o     (gameOver),
        .state_o         (state)
    );

    assign rowFull = (scanRow < 5'd30) ? fullRows[scanRow] : 1'b0;

    always #5 frameClk = ~frameClk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] key, input logic bd, input logic bl,
                                 input logic br, input logic brot, input logic sb);
        keycode      = key;
        blockedDown  = bd;
        blockedLeft  = bl;
        blockedRight = br;
        blockedRot   = brot;
        spawnBlocked = sb;
    endtask

    // Advance one frame and sample 1 time unit after the edge; a clear_row seen
    // during the frame shifts the rows above the scanned row down by one.
    task automatic tick();
        logic sawClear;
        int   clearedRow;
        sawClear   = clearRow;
        clearedRow = int'(scanRow);
        @(posedge frameClk);
        #1;
        if (sawClear) begin
            for (int r = 29; r > 0; r--) begin
                if (r <= clearedRow) fullRows[r] = fullRows[r-1];
            end
            fullRows[0] = 1'b0;
        end
    endtask

    task automatic measureGap(input int budget, output int gap);
        gap = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (stepY) begin
                gap = i;
                break;
            end
        end
    endtask

    task automatic waitForState(input int target, input int budget, output int waited);
        waited = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (int'(state) == target) begin
                waited = i;
                break;
            end
        end
    endtask

    task automatic runScan(input int budget, output int clears, output int badRows,
                           output int spawnSeen);
        clears    = 0;
        badRows   = 0;
        spawnSeen = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (clearRow) begin
                clears++;
                if (scanRow != 5'd29) badRows++;
            end
            if (spawn) begin
                spawnSeen = 1;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no completion, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gap, waited, clears, badRows, spawnSeen, steps, strobeSeen;
        int pulseFrames[$];
        int expectedFrames[$];

        fullRows = '0;
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("reset_state", int'(state), ST_SPAWN);
        checkOutput("reset_strobes", int'({spawn, stepX, stepY, rotate, lock, clearRow}), 0);
        checkOutput("reset_scan_row", int'(scanRow), 0);
        checkOutput("reset_lines", int'(lines), 0);
        checkOutput("reset_level", int'(level), 0);
        checkOutput("reset_game_over", int'(gameOver), 0);

        // Reset high in cycle 0; SPAWN decides in cycle 1; spawn strobe in cycle 2.
        $display("[TB] spawn and gravity");
        reset = 1'b0;
        checkOutput("spawn_before_release", int'(spawn), 0);
        tick();
        checkOutput("spawn_first", int'(spawn), 1);
        checkOutput("state_after_spawn", int'(state), ST_FALL);
        measureGap(60, gap);
        checkOutput("gravity_gap_first", gap, 48);
        measureGap(60, gap);
        checkOutput("gravity_gap_second", gap, 48);
        checkOutput("level_zero", int'(level), 0);

        $display("[TB] soft drop, landing, lock delay");
        keycode = KEY_SOFT;
        for (int i = 0; i < 5; i++) begin
            measureGap(8, gap);
            checkOutput("soft_drop_gap", gap, 2);
        end
        blockedDown = 1'b1;
        waitForState(ST_LOCKWAIT, 8, waited);
        checkOutput("landing_to_lockwait", waited, 2);
        waitForState(ST_LOCK, 100, waited);
        checkOutput("lock_delay_frames", waited, 30);
        tick();
        checkOutput("lock_pulse", int'(lock), 1);
        checkOutput("scan_state", int'(state), ST_SCAN);
        checkOutput("scan_start_row", int'(scanRow), 29);
        blockedDown = 1'b0;
        keycode     = 8'h00;
        tick();
        checkOutput("scan_hold_after_lock", int'(scanRow), 29);
        tick();
        checkOutput("scan_decrement", int'(scanRow), 28);
        runScan(60, clears, badRows, spawnSeen);
        checkOutput("scan_empty_clears", clears, 0);
        checkOutput("scan_empty_respawn", spawnSeen, 1);

        $display("[TB] blocked lateral and deferral");
        tick();
        keycode     = KEY_LEFT;
        blockedLeft = 1'b1;
        tick();
        checkOutput("blocked_left_none", int'(stepX), 0);
        tick();
        checkOutput("blocked_left_still_none", int'(stepX), 0);
        repeat (44) tick();
        blockedLeft = 1'b0;
        keycode     = KEY_RIGHT;
        tick();
        checkOutput("deferral_step_x", int'(stepX), 1);
        checkOutput("deferral_no_step_y", int'(stepY), 0);
        tick();
        checkOutput("deferral_busy", int'(stepY), 0);
        tick();
        checkOutput("deferral_step_y", int'(stepY), 1);
        tick();
        keycode = KEY_LEFT;
        tick();
        checkOutput("left_step_x", int'(stepX), 3);
        tick();
        keycode    = KEY_ROT;
        blockedRot = 1'b1;
        tick();
        checkOutput("rotate_blocked", int'(rotate), 0);
        blockedRot = 1'b0;
        keycode    = 8'h00;
        tick();
        keycode = KEY_ROT;
        tick();
        checkOutput("rotate_pulse", int'(rotate), 1);

        $display("[TB] hard drop and line clear");
        fullRows[29] = 1'b1;
        fullRows[28] = 1'b1;
        tick();
        keycode = KEY_HARD;
        tick();
        checkOutput("hard_state", int'(state), ST_HARD);
        steps = 0;
        for (int i = 0; i < 20 && int'(state) != ST_LOCK; i++) begin
            tick();
            if (stepY) begin
                steps++;
                if (steps == 3) blockedDown = 1'b1;
            end
        end
        checkOutput("hard_steps", steps, 3);
        checkOutput("hard_reaches_lock", int'(state), ST_LOCK);
        tick();
        checkOutput("hard_lock_pulse", int'(lock), 1);
        blockedDown = 1'b0;
        runScan(100, clears, badRows, spawnSeen);
        checkOutput("clear_count", clears, 2);
        checkOutput("clear_rows_at_29", badRows, 0);
        checkOutput("clear_respawn", spawnSeen, 1);
        checkOutput("lines_two", int'(lines), 2);

        $display("[TB] level-up");
        fullRows[29:22] = 8'hFF;
        blockedDown     = 1'b1;
        tick();
        keycode = 8'h00;
        tick();
        keycode = KEY_HARD;
        tick();
        checkOutput("levelup_hard_state", int'(state), ST_HARD);
        waitForState(ST_LOCK, 10, waited);
        checkOutput("levelup_lock_wait", waited, 1);
        blockedDown = 1'b0;
        runScan(200, clears, badRows, spawnSeen);
        checkOutput("levelup_clears", clears, 8);
        checkOutput("levelup_respawn", spawnSeen, 1);
        checkOutput("lines_ten", int'(lines), 10);
        checkOutput("level_one", int'(level), 1);
        keycode = 8'h00;
        measureGap(60, gap);
        checkOutput("gravity_gap_level1", gap, 44);

        $display("[TB] game over");
        spawnBlocked = 1'b1;
        blockedDown  = 1'b1;
        tick();
        keycode = KEY_HARD;
        waitForState(ST_OVER, 120, waited);
        checkOutput("over_state", int'(state), ST_OVER);
        checkOutput("game_over_flag", int'(gameOver), 1);
        strobeSeen = 0;
        for (int i = 0; i < 12; i++) begin
            keycode = (i % 2 == 1) ? KEY_HARD : KEY_LEFT;
            tick();
            if (spawn || stepX != 2'b00 || stepY || rotate || lock || clearRow) strobeSeen++;
        end
        checkOutput("over_no_strobes", strobeSeen, 0);
        checkOutput("over_sticky", int'(gameOver), 1);
        reset = 1'b1;
        tick();
        checkOutput("reset_from_over_state", int'(state), ST_SPAWN);
        checkOutput("reset_from_over_flag", int'(gameOver), 0);
        checkOutput("reset_from_over_lines", int'(lines), 0);
        checkOutput("reset_from_over_level", int'(level), 0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        checkOutput("respawn_after_reset", int'(spawn), 1);

        $display("[TB] held right key");
        tick();
        keycode = KEY_RIGHT;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (stepX != 2'b00) begin
                pulseFrames.push_back(i);
                checkOutput("held_right_dir", int'(stepX), 1);
            end
        end
`ifdef DROP_SEQ_AUTOREPEAT_EN
        expectedFrames = '{0, 16, 20, 24, 28};
`else
        expectedFrames = '{0};
`endif
        checkOutput("held_right_pulses", pulseFrames.size(), expectedFrames.size());
        for (int i = 0; i < expectedFrames.size() && i < pulseFrames.size(); i++) begin
            checkOutput("held_right_frame", pulseFrames[i], expectedFrames[i]);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
